// File: rtl/csa_add_arbiter.sv
// csa_add_arbiter
//   Two requesters share one 8-bit carry-skip adder. Requests are granted
//   round-robin, the operands are captured at the handshake, the sum is
//   registered one cycle later, and the result is held until the consumer
//   takes it.
//
// Parameters
//   PRIORITY_INIT : requester that wins a tie on the first grant after reset.
//
// Ports
//   clk                    : clock, all state updates on the rising edge
//   rst                    : asynchronous active-high reset
//   req0_valid/req1_valid  : requester n presents an operation
//   req0_ready/req1_ready  : operation from requester n accepted this cycle
//   req0_a/_b, req1_a/_b   : 8-bit operands of requester n
//   rsp_valid              : result available
//   rsp_ready              : consumer accepts the result
//   rsp_sum                : 8-bit sum
//   rsp_cout               : carry out of bit 7
//   rsp_id                 : requester that issued the result
//
// Build option
//   CSA_ARB_SATURATE_EN : when defined, rsp_sum saturates to 8'hFF whenever
//                         the carry out is set (rsp_cout still reports it).

module csa_add_arbiter #(
  parameter int unsigned PRIORITY_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_sum,
  output logic       rsp_cout,
  output logic       rsp_id
);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  // After reset the "last granted" requester is the other one, so a tie
  // goes to PRIORITY_INIT first.
  localparam logic LAST_GRANT_INIT = ~PRIORITY_INIT[0];

  state_t     state_reg, state_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic       id_reg, id_next;
  logic       last_grant_reg, last_grant_next;
  logic [7:0] sum_reg, sum_next;
  logic       cout_reg, cout_next;

  logic       grant;
  logic       any_valid;

  // ---------------------------------------------------------------------
  // Carry-skip adder: two 4-bit ripple blocks. Each block's carry out is
  // bypassed by its incoming carry when every bit of the block propagates.
  // ---------------------------------------------------------------------
  logic [7:0] prop;
  logic [7:0] gen;
  logic [8:1] ripple_c;    // ripple carry out of bit gi lands in ripple_c[gi+1]
  logic [1:0] blk_cin;
  logic [1:0] blk_skip;
  logic       add_cout;
  logic [7:0] add_sum;
  logic [7:0] add_sum_final;

  assign prop = a_reg ^ b_reg;
  assign gen  = a_reg & b_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      if (gi % 4 == 0) begin : g_blk_lsb
        assign ripple_c[gi+1] = gen[gi] | (prop[gi] & blk_cin[gi/4]);
        assign add_sum[gi]    = prop[gi] ^ blk_cin[gi/4];
      end else begin : g_blk_inner
        assign ripple_c[gi+1] = gen[gi] | (prop[gi] & ripple_c[gi]);
        assign add_sum[gi]    = prop[gi] ^ ripple_c[gi];
      end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_blk
      assign blk_skip[gi] = &prop[gi*4 +: 4];
    end
  endgenerate

  assign blk_cin[0] = 1'b0;
  assign blk_cin[1] = blk_skip[0] ? blk_cin[0] : ripple_c[4];
  assign add_cout   = blk_skip[1] ? blk_cin[1] : ripple_c[8];

`ifdef CSA_ARB_SATURATE_EN
  assign add_sum_final = add_cout ? 8'hFF : add_sum;
`else
  assign add_sum_final = add_sum;
`endif

  // ---------------------------------------------------------------------
  // Round-robin grant: a lone requester always wins; on a tie the one not
  // granted last wins.
  // ---------------------------------------------------------------------
  always_comb begin
    grant     = 1'b0;
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readies are gated by rst so they are low for the whole reset period,
  // not just from the first clock edge.
  assign req0_ready = (state_reg == IDLE) && !rst && any_valid && !grant;
  assign req1_ready = (state_reg == IDLE) && !rst && any_valid &&  grant;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    id_next         = id_reg;
    last_grant_next = last_grant_reg;
    sum_next        = sum_reg;
    cout_next       = cout_reg;

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          a_next          = grant ? req1_a : req0_a;
          b_next          = grant ? req1_b : req0_b;
          id_next         = grant;
          last_grant_next = grant;
          state_next      = ADD;
        end
      end
      ADD: begin
        sum_next   = add_sum_final;
        cout_next  = add_cout;
        state_next = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= 8'h00;
      b_reg          <= 8'h00;
      id_reg         <= 1'b0;
      last_grant_reg <= LAST_GRANT_INIT;
      sum_reg        <= 8'h00;
      cout_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      id_reg         <= id_next;
      last_grant_reg <= last_grant_next;
      sum_reg        <= sum_next;
      cout_reg       <= cout_next;
    end
  end

  assign rsp_valid = (state_reg == HOLD);
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = cout_reg;
  assign rsp_id    = id_reg;

endmodule

// File: tb/tb_csa_add_arbiter.sv
module tb_csa_add_arbiter;

  localparam int P = 0;
  localparam int M_IDLE = 0;
  localparam int M_ADD  = 1;
  localparam int M_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_sum;
  logic       rsp_cout;
  logic       rsp_id;

  always #5 clk = ~clk;

  csa_add_arbiter #(.PRIORITY_INIT(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  typedef struct {
    logic       id;
    logic [7:0] sum;
    logic       cout;
  } rsp_t;

  rsp_t       sb[$];
  logic       got_id[$];
  logic [7:0] got_sum[$];
  logic       got_cout[$];

  int   checks = 0;
  int   errors = 0;
  int   m;
  logic tb_last;
  bit   hold_valid;
  int   hs_count = 0;

`ifdef CSA_ARB_SATURATE_EN
  localparam logic [7:0] WRAP_00 = 8'hFF;
`else
  localparam logic [7:0] WRAP_00 = 8'h00;
`endif

  function automatic rsp_t model(logic id, logic [7:0] a, logic [7:0] b);
    rsp_t r;
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    r.id   = id;
    r.cout = t[8];
    r.sum  = t[7:0];
`ifdef CSA_ARB_SATURATE_EN
    if (t[8]) r.sum = 8'hFF;
`endif
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m       = M_IDLE;
    tb_last = (P == 0) ? 1'b1 : 1'b0;
  endtask

  // One clock cycle: sample and check at the falling edge, then advance.
  task automatic tick();
    logic g;
    bit   drop0, drop1;
    rsp_t e;
    drop0 = 0;
    drop1 = 0;
    @(negedge clk);
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_cout", rsp_cout, 0);
      chk("rst_rsp_id", rsp_id, 0);
    end else begin
      chk("rsp_valid", rsp_valid, (m == M_HOLD));
      chk("ready_excl", req0_ready & req1_ready, 0);
      case (m)
        M_IDLE: begin
          if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? ~tb_last : req1_valid;
            chk("grant_ready0", req0_ready, !g);
            chk("grant_ready1", req1_ready, g);
            sb.push_back(model(g, g ? req1_a : req0_a, g ? req1_b : req0_b));
            tb_last = g;
            m = M_ADD;
            hs_count++;
            if (g) drop1 = 1; else drop0 = 1;
          end else begin
            chk("idle_ready0", req0_ready, 0);
            chk("idle_ready1", req1_ready, 0);
          end
        end
        M_ADD: begin
          chk("add_ready0", req0_ready, 0);
          chk("add_ready1", req1_ready, 0);
          m = M_HOLD;
        end
        default: begin
          chk("hold_ready0", req0_ready, 0);
          chk("hold_ready1", req1_ready, 0);
          if (sb.size() > 0) begin
            e = sb[0];
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_cout", rsp_cout, e.cout);
            chk("rsp_id", rsp_id, e.id);
            if (rsp_ready) begin
              void'(sb.pop_front());
              got_id.push_back(rsp_id);
              got_sum.push_back(rsp_sum);
              got_cout.push_back(rsp_cout);
              $display("rsp id=%0d sum=%02h cout=%0d", rsp_id, rsp_sum, rsp_cout);
              m = M_IDLE;
            end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (drop0) begin
      if (hold_valid) begin
        req0_a = 8'($urandom); req0_b = 8'($urandom);
      end else req0_valid = 1'b0;
    end
    if (drop1) begin
      if (hold_valid) begin
        req1_a = 8'($urandom); req1_b = 8'($urandom);
      end else req1_valid = 1'b0;
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((m != M_IDLE || sb.size() != 0 || req0_valid || req1_valid) && n < budget) begin
      tick();
      n++;
    end
    if (m != M_IDLE || sb.size() != 0 || req0_valid || req1_valid) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=busy expected=idle within %0d cycles", budget);
    end
  endtask

  initial begin
    int base;
    int start_hs;
    int n;

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    hold_valid = 0;
    model_reset();

    // Reset state, with a request pending that must not be accepted.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55;
    tick(); tick();

    // Release reset with a request already present: accepted on first edge.
    rst = 1'b0;
    req0_a = 8'h12; req0_b = 8'h34;
    drain(20);
    chk("t1_id", got_id[got_id.size()-1], 0);
    chk("t1_sum", got_sum[got_sum.size()-1], 8'h46);
    chk("t1_cout", got_cout[got_cout.size()-1], 0);

    // Tie right after reset: PRIORITY_INIT first, then the other.
    rst = 1'b1; model_reset();
    tick();
    rst = 1'b0;
    req0_valid = 1; req0_a = 8'h0F; req0_b = 8'h01;
    req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h10;
    drain(30);
    n = got_id.size();
    chk("t2_id_a", got_id[n-2], 0);
    chk("t2_sum_a", got_sum[n-2], 8'h10);
    chk("t2_id_b", got_id[n-1], 1);
    chk("t2_sum_b", got_sum[n-1], WRAP_00);
    chk("t2_cout_b", got_cout[n-1], 1);

    // Both held valid for four operations: strict alternation.
    base = got_id.size();
    start_hs = hs_count;
    hold_valid = 1;
    req0_valid = 1; req0_a = 8'h21; req0_b = 8'h43;
    req1_valid = 1; req1_a = 8'h9C; req1_b = 8'h7D;
    n = 0;
    while (hs_count - start_hs < 4 && n < 60) begin
      tick();
      n++;
    end
    hold_valid = 0;
    req0_valid = 0; req1_valid = 0;
    drain(20);
    if (got_id.size() - base < 4) begin
      checks++; errors++;
      $error("FAIL rr_count observed=%0d expected=4", got_id.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) chk("rr_id", got_id[base+i], i % 2);
    end

    // Skip-path operands.
    req1_valid = 1; req1_a = 8'h0F; req1_b = 8'h00;
    drain(20);
    chk("skip1_sum", got_sum[got_sum.size()-1], 8'h0F);
    chk("skip1_cout", got_cout[got_cout.size()-1], 0);
    req0_valid = 1; req0_a = 8'hFF; req0_b = 8'h01;
    drain(20);
    chk("skip2_sum", got_sum[got_sum.size()-1], WRAP_00);
    chk("skip2_cout", got_cout[got_cout.size()-1], 1);

    // Backpressure: result held for 5 cycles, no grants meanwhile.
    rsp_ready = 1'b0;
    req0_valid = 1; req0_a = 8'h80; req0_b = 8'h80;
    tick(); tick();
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_sum", rsp_sum, WRAP_00);
    end
    rsp_ready = 1'b1;
    drain(20);
    chk("bp_next_id", got_id[got_id.size()-1], 1);
    chk("bp_next_sum", got_sum[got_sum.size()-1], 8'h03);

    // Reset while in ADD: operation discarded, tie then goes to PRIORITY_INIT.
    req1_valid = 1; req1_a = 8'h33; req1_b = 8'h44;
    tick();
    rst = 1'b1;
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h06;
    req1_valid = 1; req1_a = 8'h07; req1_b = 8'h08;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_ready0", req0_ready, 0);
    chk("arst_ready1", req1_ready, 0);
    model_reset();
    n = got_id.size();
    tick(); tick();
    rst = 1'b0;
    drain(30);
    chk("arst_count", got_id.size() - n, 2);
    chk("arst_id", got_id[n], P);
    chk("arst_sum", got_sum[n], 8'h0B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_add_arbiter.md
CSA_ADD_ARBITER -- requirements
Module: csa_add_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_INIT, default 0: requester index granted first after reset when both requesters are valid.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1 each  operation from requester n accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  8 each  operands of requester n.
REQ-007 SHALL have port rsp_valid  output  1  result available.
REQ-008 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-009 SHALL have port rsp_sum  output  8  result sum.
REQ-010 SHALL have port rsp_cout  output  1  carry out of bit 7.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that issued the result.

Function
REQ-012 SHALL share one 8-bit carry-skip adder (two 4-bit ripple blocks, skip mux on the lower-block carry, cin=0) between both requesters.
REQ-013 SHALL implement FSM states IDLE, ADD, HOLD; reset state IDLE.
REQ-014 IDLE: no valid -> stay IDLE; any valid -> assert ready combinationally to the granted requester only, capture its a/b and id, go to ADD.
REQ-015 Grant: one valid -> that requester; both valid -> the requester not granted last (round-robin), last_grant updated on every handshake.
REQ-016 ADD: register sum = (a+b) mod 256 and cout = bit 8 of a+b into rsp_sum/rsp_cout; go to HOLD.
REQ-017 HOLD: rsp_valid=1; rsp_sum/rsp_cout/rsp_id stable until rsp_ready=1; rsp_valid&rsp_ready -> IDLE next cycle.
REQ-018 Latency: handshake in cycle N -> rsp_valid=1 in cycle N+2; minimum issue interval 3 cycles.
REQ-019 req0_ready and req1_ready SHALL never both be 1, and SHALL be 0 outside IDLE.
REQ-020 Requester valid deasserted before handshake SHALL be ignored without state change; operands SHALL be sampled only at handshake.
REQ-021 rsp_ready outside HOLD SHALL have no effect.

Reset
REQ-022 rst=1 SHALL asynchronously force state IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, req*_ready=0, last_grant = 1-PRIORITY_INIT.
REQ-023 Reset during ADD or HOLD SHALL discard the in-flight operation; no result emitted after release.
REQ-024 First rising edge after rst falls SHALL be able to accept a request.

Configuration
REQ-025 Macro CSA_ARB_SATURATE_EN defined: if carry out of bit 7 is 1, rsp_sum SHALL be 8'hFF; rsp_cout still reports the carry.
REQ-026 Macro undefined: rsp_sum SHALL be the wrapped sum (a+b) mod 256.

Verification
REQ-027 req0 a=8'h12,b=8'h34 alone -> req0_ready same cycle, two cycles later rsp_valid=1, rsp_sum=8'h46, rsp_cout=0, rsp_id=0.
REQ-028 Both valid after reset, PRIORITY_INIT=0, req0 (8'h0F+8'h01), req1 (8'hF0+8'h10) -> results in order id0 sum 8'h10, then id1 sum 8'h00 cout=1 (8'hFF if CSA_ARB_SATURATE_EN).
REQ-029 Both held valid continuously for 4 operations -> rsp_id sequence 0,1,0,1; no cycle with both readies high.
REQ-030 Skip path: a=8'h0F,b=8'h00 and a=8'hFF,b=8'h01 -> sums 8'h0F (cout 0) and 8'h00 (cout 1).
REQ-031 rsp_ready held 0 for 5 cycles in HOLD -> rsp_valid and rsp_sum unchanged, both req*_ready stay 0; rsp_ready=1 -> IDLE next cycle.
REQ-032 Assert rst during ADD -> rsp_valid=0 immediately and after release; next request yields correct result with PRIORITY_INIT winning a tie.
